pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised chain of pipeline registers for the pipelined CPU datapath. It supersedes single fixed-width stage registers with a single write-enable.
- Each stage carries WIDTH bits of payload plus a valid bit. Each stage has its own hold (stall) input and its own flush input.
- Stalls propagate upstream. A bubble is inserted automatically downstream of a held stage.
- Provides occupancy and stall-cycle statistics for hazard-unit debug.

Parameters:
- WIDTH, 32, payload bits per stage (>=1)
- STAGES, 3, number of register stages (>=1); stage 0 captures data_i, stage STAGES-1 drives data_o
- BUBBLE_VAL, 0, WIDTH-bit payload value loaded on reset, flush and bubble insertion

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- data_i  input  WIDTH  payload into stage 0
- valid_i  input  1  data_i is a real instruction/transaction
- stall_i  input  STAGES  bit k requests that stage k hold its contents
- flush_i  input  STAGES  bit k forces stage k to a bubble on the next edge
- ready_o  output  1  stage 0 will accept data_i this cycle
- data_o  output  WIDTH  payload of stage STAGES-1
- valid_o  output  1  valid bit of stage STAGES-1
- stage_valid_o  output  STAGES  valid bit of every stage, bit k = stage k
- occupancy_o  output  $clog2(STAGES+1)  number of valid stages
- stall_cnt_o  output  16  saturating count of cycles with valid_i=1 and ready_o=0

Behaviour:
Reset:
- When rst_i=1 at an edge, all stage payloads become BUBBLE_VAL.
- All valid bits and stall_cnt_o become 0.
- Consequently, during reset: data_o=BUBBLE_VAL, valid_o=0, occupancy_o=0, ready_o=~stall_i OR-reduced.
- Reset overrides all other inputs, including mid-stall and mid-flush.

Effective hold (combinational):
- hold[k] = OR of stall_i[j] for j=k..STAGES-1, i.e. a stall of any downstream stage freezes every upstream stage.
- ready_o = ~hold[0].

Per-stage update at each edge (rst_i=0), stage k, priority high to low:
1. flush_i[k]=1: payload=BUBBLE_VAL, valid=0. This applies even if hold[k]=1 and discards any incoming entry.
2. hold[k]=1: payload and valid unchanged.
3. k>0 and hold[k-1]=1 (upstream held, this stage advancing): bubble inserted; payload=BUBBLE_VAL, valid=0.
4. Otherwise: load from the source (stage k-1, or data_i/valid_i for k=0).

Other rules:
- A bubble's payload is always BUBBLE_VAL, so zeroed control fields are guaranteed downstream.
- The last stage advances every cycle unless stall_i[STAGES-1]=1. No downstream backpressure exists beyond stall_i.
- Latency: an entry accepted at edge N appears on data_o/valid_o after edge N+STAGES-1 (STAGES register delays), assuming no holds or flushes.
- An entry with valid_i=0 is carried as a normal payload with valid=0. It is not replaced by BUBBLE_VAL.
- occupancy_o = popcount(stage_valid_o), combinational from the registers.
- stall_cnt_o increments by 1 at each edge where valid_i=1 and ready_o=0. It saturates at 16'hFFFF and is cleared only by reset.
- Simultaneous stall_i[k] and flush_i[k]: the flush wins. Upstream stages remain held, because hold[] depends only on stall_i.
- STAGES=1: rule 3 never applies. ready_o = ~stall_i[0].

Test Plan:
1. WIDTH=8, STAGES=3. Reset, then feed valid_i=1 with 0x11, 0x22, 0x33 on consecutive cycles, no stalls -> 0x11 with valid_o=1 after the 3rd edge, 0x22 and 0x33 on the following edges; occupancy_o reaches 3.
2. Pipeline full with 0x11/0x22/0x33, stall_i=3'b001 for 2 cycles -> stage 0 holds 0x33. Stages 1 and 2 receive bubbles (data 0x00, valid 0). ready_o=0. stall_cnt_o=2 if valid_i stays 1.
3. stall_i=3'b100 for 1 cycle with a full pipe -> all stages freeze, data_o holds 0x11, ready_o=0; the chain resumes unchanged afterwards.
4. flush_i=3'b011 with a full pipe -> the next edge gives stage_valid_o=3'b100 (stage 2 advanced 0x22 from stage 1? No: stage 2 takes stage 1's old value 0x22, valid=1). Stages 0 and 1 hold 0x00.
5. stall_i[1]=1 and flush_i[1]=1 together -> stage 1 becomes a bubble, stage 0 stays frozen, ready_o=0.
6. Assert rst_i during a stall with stall_cnt_o=5 -> after one edge all valids and stall_cnt_o are 0 and data_o=BUBBLE_VAL. Separately, force stall_cnt_o to 0xFFFF with continuous stall -> it stays at 0xFFFF.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Parametrised chain of pipeline registers with per-stage stall and flush,
// automatic bubble insertion below a held stage, and hazard-debug statistics.
module pipe_reg_chain #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      STAGES     = 3,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         valid_i,
    input  logic [STAGES-1:0]            stall_i,
    input  logic [STAGES-1:0]            flush_i,
    output logic                         ready_o,
    output logic [WIDTH-1:0]             data_o,
    output logic                         valid_o,
    output logic [STAGES-1:0]            stage_valid_o,
    output logic [$clog2(STAGES+1)-1:0]  occupancy_o,
    output logic [15:0]                  stall_cnt_o
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [15:0]       stall_cnt_q;
    logic [15:0]       stall_cnt_d;

    logic [STAGES-1:0] hold;
    logic [WIDTH-1:0]  src_data [STAGES];
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_hold;
    logic [OCC_W-1:0]  occ;

    // A stall anywhere downstream freezes every stage above it.
    always_comb begin : hold_chain
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            acc                  = acc | stall_i[STAGES-1-i];
            hold[STAGES-1-i]     = acc;
        end
    end

    // Source of each stage; stage 0 is fed from the input and never sees an upstream hold.
    always_comb begin
        src_data[0]  = data_i;
        src_valid    = '0;
        src_hold     = '0;
        src_valid[0] = valid_i;
        for (int unsigned i = 1; i < STAGES; i++) begin
            src_data[i]  = data_q[i-1];
            src_valid[i] = valid_q[i-1];
            src_hold[i]  = hold[i-1];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            data_d[i]  = data_q[i];
            valid_d[i] = valid_q[i];
            if (flush_i[i]) begin
                data_d[i]  = BUBBLE_VAL;
                valid_d[i] = 1'b0;
            end else if (hold[i]) begin
                data_d[i]  = data_q[i];
                valid_d[i] = valid_q[i];
            end else if (src_hold[i]) begin
                data_d[i]  = BUBBLE_VAL;
                valid_d[i] = 1'b0;
            end else begin
                data_d[i]  = src_data[i];
                valid_d[i] = src_valid[i];
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_i && hold[0] && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= BUBBLE_VAL;
            end
            valid_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ready_o       = ~hold[0];
    assign data_o        = data_q[STAGES-1];
    assign valid_o       = valid_q[STAGES-1];
    assign stage_valid_o = valid_q;
    assign occupancy_o   = occ;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: two instances differing only in bubble value,
// checked every cycle against a behavioural model plus literal spot checks.
module tb_pipe_reg_chain;

    localparam int unsigned W    = 8;
    localparam int unsigned S    = 3;
    localparam logic [7:0]  BV_A = 8'h00;
    localparam logic [7:0]  BV_B = 8'hC3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i;
    logic [7:0]   data_i;
    logic         valid_i;
    logic [2:0]   stall_i;
    logic [2:0]   flush_i;

    logic         ready_a, valid_a, ready_b, valid_b;
    logic [7:0]   data_a, data_b;
    logic [2:0]   sv_a, sv_b;
    logic [1:0]   occ_a, occ_b;
    logic [15:0]  cnt_a, cnt_b;

    pipe_reg_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_VAL(BV_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .ready_o(ready_a),
        .data_o(data_a), .valid_o(valid_a), .stage_valid_o(sv_a),
        .occupancy_o(occ_a), .stall_cnt_o(cnt_a)
    );

    pipe_reg_chain #(.WIDTH(W), .STAGES(S), .BUBBLE_VAL(BV_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .ready_o(ready_b),
        .data_o(data_b), .valid_o(valid_b), .stage_valid_o(sv_b),
        .occupancy_o(occ_b), .stall_cnt_o(cnt_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: stage contents as plain arrays, updated once per edge.
    logic [7:0]  m_da [S];
    logic [7:0]  m_db [S];
    logic        m_v  [S];
    logic [15:0] m_cnt;
    bit          chk_en = 1'b0;
    bit          any_down;

    always @(posedge clk) begin
        if (rst_i) begin
            for (int k = 0; k < S; k++) begin
                m_da[k] = BV_A;
                m_db[k] = BV_B;
                m_v[k]  = 1'b0;
            end
            m_cnt  = 16'd0;
            chk_en = 1'b1;
        end else begin
            if (valid_i && (stall_i != 3'b000) && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
            // Walk downstream-first so each stage still sees its neighbour's old value.
            for (int k = S - 1; k >= 0; k--) begin
                any_down = 1'b0;
                for (int j = k; j < S; j++) if (stall_i[j]) any_down = 1'b1;
                if (flush_i[k]) begin
                    m_da[k] = BV_A; m_db[k] = BV_B; m_v[k] = 1'b0;
                end else if (any_down) begin
                    // frozen
                end else if (k > 0 && stall_i[k-1]) begin
                    // only stall_i[k-1] can make the upstream stage held while this one moves
                    m_da[k] = BV_A; m_db[k] = BV_B; m_v[k] = 1'b0;
                end else if (k == 0) begin
                    m_da[0] = data_i; m_db[0] = data_i; m_v[0] = valid_i;
                end else begin
                    m_da[k] = m_da[k-1]; m_db[k] = m_db[k-1]; m_v[k] = m_v[k-1];
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0] ev;
        logic [1:0] eocc;
        #2;
        if (chk_en) begin
            eocc = 2'd0;
            for (int k = 0; k < S; k++) begin
                ev[k] = m_v[k];
                eocc  = eocc + 2'(m_v[k]);
            end
            chk("data_o_a", 32'(data_a), 32'(m_da[S-1]));
            chk("data_o_b", 32'(data_b), 32'(m_db[S-1]));
            chk("valid_o_a", 32'(valid_a), 32'(m_v[S-1]));
            chk("valid_o_b", 32'(valid_b), 32'(m_v[S-1]));
            chk("stage_valid_a", 32'(sv_a), 32'(ev));
            chk("stage_valid_b", 32'(sv_b), 32'(ev));
            chk("occupancy_a", 32'(occ_a), 32'(eocc));
            chk("occupancy_b", 32'(occ_b), 32'(eocc));
            chk("stall_cnt_a", 32'(cnt_a), 32'(m_cnt));
            chk("stall_cnt_b", 32'(cnt_b), 32'(m_cnt));
            chk("ready_a", 32'(ready_a), 32'(stall_i == 3'b000));
            chk("ready_b", 32'(ready_b), 32'(stall_i == 3'b000));
        end
    end

    task automatic drv(input logic [7:0] d, input logic v, input logic [2:0] st,
                       input logic [2:0] fl, input logic r);
        @(negedge clk);
        data_i  = d;
        valid_i = v;
        stall_i = st;
        flush_i = fl;
        rst_i   = r;
    endtask

    // Leaves the chain holding 0x33/0x22/0x11 in stages 0/1/2.
    task automatic load3();
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b1);
        drv(8'h11, 1'b1, 3'b000, 3'b000, 1'b0);
        drv(8'h22, 1'b1, 3'b000, 3'b000, 1'b0);
        drv(8'h33, 1'b1, 3'b000, 3'b000, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1; data_i = '0; valid_i = 1'b0; stall_i = '0; flush_i = '0;

        // Reset state, then fill.
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b1);
        drv(8'h11, 1'b1, 3'b000, 3'b000, 1'b0);
        #3;
        chk("lit_reset_valid", 32'(valid_a), 32'd0);
        chk("lit_reset_occ", 32'(occ_a), 32'd0);
        chk("lit_reset_data_b", 32'(data_b), 32'hC3);
        chk("lit_reset_cnt", 32'(cnt_a), 32'd0);
        chk("lit_reset_ready", 32'(ready_a), 32'd1);
        drv(8'h22, 1'b1, 3'b000, 3'b000, 1'b0);
        drv(8'h33, 1'b1, 3'b000, 3'b000, 1'b0);
        drv(8'h44, 1'b1, 3'b001, 3'b000, 1'b0);
        #3;
        chk("lit_fill_data", 32'(data_a), 32'h11);
        chk("lit_fill_valid", 32'(valid_a), 32'd1);
        chk("lit_fill_occ", 32'(occ_a), 32'd3);
        chk("lit_stall0_ready", 32'(ready_a), 32'd0);
        drv(8'h44, 1'b1, 3'b001, 3'b000, 1'b0);
        drv(8'h55, 1'b1, 3'b000, 3'b000, 1'b0);
        #3;
        chk("lit_stall0_cnt", 32'(cnt_a), 32'd2);
        chk("lit_stall0_sv", 32'(sv_a), 32'b001);
        chk("lit_stall0_bubble_b", 32'(data_b), 32'hC3);

        // Last-stage stall freezes everything.
        load3();
        drv(8'h44, 1'b1, 3'b100, 3'b000, 1'b0);
        #3;
        chk("lit_stall2_ready", 32'(ready_a), 32'd0);
        drv(8'h44, 1'b1, 3'b000, 3'b000, 1'b0);
        #3;
        chk("lit_stall2_data", 32'(data_a), 32'h11);
        chk("lit_stall2_sv", 32'(sv_a), 32'b111);
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
        #3;
        chk("lit_resume_data", 32'(data_a), 32'h22);

        // Flush of stages 0 and 1.
        load3();
        drv(8'h44, 1'b1, 3'b000, 3'b011, 1'b0);
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
        #3;
        chk("lit_flush_sv", 32'(sv_a), 32'b100);
        chk("lit_flush_data", 32'(data_a), 32'h22);

        // Stall and flush on the same stage.
        load3();
        drv(8'h44, 1'b1, 3'b010, 3'b010, 1'b0);
        #3;
        chk("lit_stfl_ready", 32'(ready_a), 32'd0);
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
        #3;
        chk("lit_stfl_sv", 32'(sv_a), 32'b001);

        // Reset in the middle of a stall.
        load3();
        repeat (5) drv(8'h44, 1'b1, 3'b100, 3'b000, 1'b0);
        drv(8'h44, 1'b1, 3'b100, 3'b000, 1'b1);
        #3;
        chk("lit_rst_cnt_before", 32'(cnt_a), 32'd5);
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
        #3;
        chk("lit_rst_sv", 32'(sv_a), 32'd0);
        chk("lit_rst_cnt", 32'(cnt_a), 32'd0);
        chk("lit_rst_data_b", 32'(data_b), 32'hC3);

        // Saturation of the stall counter.
        repeat (65540) drv(8'($urandom), 1'b1, 3'b001, 3'b000, 1'b0);
        drv(8'h00, 1'b1, 3'b001, 3'b000, 1'b0);
        #3;
        chk("lit_sat_cnt", 32'(cnt_a), 32'hFFFF);
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
        #3;
        chk("lit_sat_hold", 32'(cnt_b), 32'hFFFF);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [2:0] st, fl;
            for (int k = 0; k < 3; k++) begin
                st[k] = ($urandom_range(0, 3) == 0);
                fl[k] = ($urandom_range(0, 7) == 0);
            end
            drv(8'($urandom), 1'($urandom), st, fl, ($urandom_range(0, 63) == 0));
        end
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
        drv(8'h00, 1'b0, 3'b000, 3'b000, 1'b0);
        #4;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
